// File: rtl/keccak_sponge_ctrl_if.sv
// Message stream, Keccak-f core handshake and digest bundle of keccak_sponge_ctrl.
// slave = controller side, master = the message source / core / digest consumer side.
interface keccak_sponge_ctrl_if #(
    parameter int WORD_W   = 64,
    parameter int DIGEST_W = 256
);
    localparam int BW = $clog2(WORD_W / 8) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   in_data;
    logic                in_last;
    logic [BW-1:0]       in_bytes;
    logic                perm_start;
    logic [1599:0]       perm_state_out;
    logic                perm_done;
    logic [1599:0]       perm_state_in;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;
    logic                digest_ack;

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, perm_done, perm_state_in, digest_ack,
        output in_ready, perm_start, perm_state_out, digest, digest_valid
    );

    modport master (
        output in_valid, in_data, in_last, in_bytes, perm_done, perm_state_in, digest_ack,
        input  in_ready, perm_start, perm_state_out, digest, digest_valid
    );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge absorb controller: assembles RATE-bit blocks, pads pad10*1 with a domain byte,
// XORs them into the state and sequences an external Keccak-f[1600] core via start/done.
module keccak_sponge_ctrl #(
    parameter int         WORD_W   = 64,
    parameter int         RATE     = 1088,
    parameter int         DIGEST_W = 256,
    parameter logic [7:0] DOMAIN   = 8'h06
) (
    input  logic                 clk,
    input  logic                 reset,
    keccak_sponge_ctrl_if.slave  bus
);
    localparam int NW = RATE / WORD_W;
    localparam int WB = WORD_W / 8;
    localparam int RB = RATE / 8;
    localparam int BW = $clog2(WB) + 1;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = $clog2(RB + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_XOR, ST_START, ST_WAIT, ST_PADBLK, ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1599:0]     s_q, s_d;
    logic [RATE-1:0]   buf_q, buf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pad_pending_q, pad_pending_d;
    logic              last_blk_q, last_blk_d;

    logic              in_ready;
    logic              perm_start;
    logic              digest_valid;
    logic [BW-1:0]     nb;
    logic [WORD_W-1:0] word;
    logic [PW-1:0]     p;
    logic              blk_end;

    // Byte count of the incoming word and the resulting pad position within the block.
    always_comb begin
        nb = BW'(WB);
        if (bus.in_last && (bus.in_bytes < BW'(WB))) nb = bus.in_bytes;
        word = '0;
        for (int j = 0; j < WB; j++) begin
            if (j < int'(nb)) word[8*j +: 8] = bus.in_data[8*j +: 8];
        end
        p       = PW'(cnt_q) * PW'(WB) + PW'(nb);
        blk_end = bus.in_last || (cnt_q == CW'(NW - 1));
    end

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        last_blk_d    = last_blk_q;
        in_ready      = 1'b0;
        perm_start    = 1'b0;
        digest_valid  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FILL;
            ST_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    buf_d[cnt_q*WORD_W +: WORD_W] = word;
                    cnt_d = cnt_q + 1'b1;
                    if (blk_end) begin
                        cnt_d   = '0;
                        state_d = ST_XOR;
                    end
                    if (bus.in_last) begin
                        last_blk_d = 1'b1;
                        // A message that exactly fills the block defers padding to an extra block.
                        if (p < PW'(RB)) begin
                            buf_d[8*p +: 8]    = buf_d[8*p +: 8] ^ DOMAIN;
                            buf_d[RATE-1 -: 8] = buf_d[RATE-1 -: 8] ^ 8'h80;
                        end else begin
                            pad_pending_d = 1'b1;
                        end
                    end
                end
            end
            ST_XOR: begin
                s_d[RATE-1:0] = s_q[RATE-1:0] ^ buf_q;
                buf_d         = '0;
                state_d       = ST_START;
            end
            ST_START: begin
                perm_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.perm_done) begin
                    s_d = bus.perm_state_in;
                    if (pad_pending_q)   state_d = ST_PADBLK;
                    else if (last_blk_q) state_d = ST_DONE;
                    else                 state_d = ST_FILL;
                end
            end
            ST_PADBLK: begin
                buf_d              = '0;
                buf_d[7:0]         = DOMAIN;
                buf_d[RATE-1 -: 8] = buf_d[RATE-1 -: 8] ^ 8'h80;
                pad_pending_d      = 1'b0;
                state_d            = ST_XOR;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                if (bus.digest_ack) begin
                    s_d        = '0;
                    last_blk_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_q           <= '0;
            buf_q         <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            last_blk_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            last_blk_q    <= last_blk_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.perm_start     = perm_start;
    assign bus.perm_state_out = s_q;
    assign bus.digest         = s_q[DIGEST_W-1:0];
    assign bus.digest_valid   = digest_valid;
endmodule
